// File: rtl/pmp_csr_file.sv
// PMP CSR storage: pmpcfg0..3 / pmpaddr0..15 with WARL legalisation, L-bit locking
// and a single-cycle response pipeline. Only entries 0-3 are implemented.
module pmp_csr_file #(
  parameter int unsigned PMP_ENTRIES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_req,
  input  logic        csr_we,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic [1:0]  csr_priv,
  output logic        csr_rvalid,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  output logic        pmp_update,
  output logic [31:0] pmpcfg0,
  output logic [31:0] pmpcfg1,
  output logic [31:0] pmpaddr0,
  output logic [31:0] pmpaddr1,
  output logic [31:0] pmpaddr2,
  output logic [31:0] pmpaddr3
);

  logic [3:0][7:0]  cfg_q, cfg_d;
  logic [3:0][31:0] addr_q, addr_d;
  logic             rvalid_q, rvalid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             illegal_q, illegal_d;
  logic             update_q, update_d;

  logic        sel_cfg, sel_cfg0, sel_addr, addr_impl, illegal, do_write;
  logic [3:0]  addr_idx;
  logic [31:0] old_val, new_val;
  logic [3:0]  addr_lock;
  logic [7:0]  byte_v;

  // Decode, lock evaluation, WARL legalisation and next-state for all storage.
  always_comb begin
    sel_cfg   = (csr_addr[11:2] == 10'h0E8);
    sel_cfg0  = (csr_addr == 12'h3A0);
    sel_addr  = (csr_addr[11:4] == 8'h3B);
    addr_idx  = csr_addr[3:0];
    addr_impl = sel_addr && ({28'd0, addr_idx} < PMP_ENTRIES);
    illegal   = !(sel_cfg || sel_addr) || (csr_priv != 2'b11);

    old_val = '0;
    if (sel_cfg0) begin
      old_val = cfg_q;
    end else if (addr_impl) begin
      old_val = addr_q[addr_idx[1:0]];
    end

    unique case (csr_op)
      2'b01:   new_val = csr_wdata;
      2'b10:   new_val = old_val | csr_wdata;
      2'b11:   new_val = old_val & ~csr_wdata;
      default: new_val = old_val;
    endcase

    // An address is frozen by its own L bit, or by a locked TOR entry above it
    // that uses it as the lower bound.
    for (int i = 0; i < 4; i++) begin
      addr_lock[i] = cfg_q[i][7];
    end
    for (int i = 0; i < 3; i++) begin
      if (cfg_q[i+1][7] && (cfg_q[i+1][4:3] == 2'b01)) begin
        addr_lock[i] = 1'b1;
      end
    end

    do_write = csr_req && !illegal && csr_we && (csr_op != 2'b00);

    cfg_d  = cfg_q;
    addr_d = addr_q;
    byte_v = '0;
    if (do_write && sel_cfg0) begin
      for (int i = 0; i < 4; i++) begin
        byte_v      = new_val[8*i +: 8];
        byte_v[6:5] = 2'b00;
        if (!byte_v[0] && byte_v[1]) begin
          byte_v[1] = 1'b0;
        end
        if (!cfg_q[i][7]) begin
          cfg_d[i] = byte_v;
        end
      end
    end
    if (do_write && addr_impl && !addr_lock[addr_idx[1:0]]) begin
      addr_d[addr_idx[1:0]] = new_val;
    end

    rvalid_d  = csr_req;
    rdata_d   = (csr_req && !illegal) ? old_val : 32'd0;
    illegal_d = csr_req && illegal;
    update_d  = (cfg_d != cfg_q) || (addr_d != addr_q);
  end

  // State and response registers; reset drops any in-flight response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q     <= '0;
      addr_q    <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      illegal_q <= 1'b0;
      update_q  <= 1'b0;
    end else begin
      cfg_q     <= cfg_d;
      addr_q    <= addr_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      illegal_q <= illegal_d;
      update_q  <= update_d;
    end
  end

  assign csr_rvalid  = rvalid_q;
  assign csr_rdata   = rdata_q;
  assign csr_illegal = illegal_q;
  assign pmp_update  = update_q;
  assign pmpcfg0     = cfg_q;
  assign pmpcfg1     = 32'd0;
  assign pmpaddr0    = addr_q[0];
  assign pmpaddr1    = addr_q[1];
  assign pmpaddr2    = addr_q[2];
  assign pmpaddr3    = addr_q[3];

endmodule

// File: tb/tb_pmp_csr_file.sv
// Self-checking bench for pmp_csr_file: architectural model plus directed vectors.
module tb_pmp_csr_file;

  localparam logic [1:0] OpRd = 2'b00, OpRw = 2'b01, OpRs = 2'b10, OpRc = 2'b11;
  localparam logic [1:0] PrivU = 2'b00, PrivS = 2'b01, PrivM = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csr_req = 1'b0, csr_we = 1'b0;
  logic [1:0]  csr_op = 2'b00, csr_priv = PrivM;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_wdata = '0;
  logic        csr_rvalid, csr_illegal, pmp_update;
  logic [31:0] csr_rdata, pmpcfg0, pmpcfg1, pmpaddr0, pmpaddr1, pmpaddr2, pmpaddr3;

  pmp_csr_file #(.PMP_ENTRIES(4)) dut (
    .clk(clk), .rst(rst), .csr_req(csr_req), .csr_we(csr_we), .csr_op(csr_op),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_priv(csr_priv),
    .csr_rvalid(csr_rvalid), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .pmp_update(pmp_update), .pmpcfg0(pmpcfg0), .pmpcfg1(pmpcfg1),
    .pmpaddr0(pmpaddr0), .pmpaddr1(pmpaddr1), .pmpaddr2(pmpaddr2), .pmpaddr3(pmpaddr3)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Architectural model: visible CSR contents and the expected response.
  bit [7:0]  m_cfg[4];
  bit [31:0] m_addr[4];
  bit        exp_rvalid, exp_illegal, exp_update;
  bit [31:0] exp_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
  endtask

  function automatic bit [31:0] m_read(input bit [11:0] a);
    if (a == 12'h3A0) return {m_cfg[3], m_cfg[2], m_cfg[1], m_cfg[0]};
    if (a >= 12'h3B0 && a <= 12'h3B3) return m_addr[a - 12'h3B0];
    return 32'd0;
  endfunction

  function automatic bit m_legal(input bit [11:0] a, input bit [1:0] p);
    if (p != PrivM) return 1'b0;
    return (a >= 12'h3A0 && a <= 12'h3A3) || (a >= 12'h3B0 && a <= 12'h3BF);
  endfunction

  function automatic bit m_addr_locked(input int i);
    if (m_cfg[i][7]) return 1'b1;
    if (i < 3 && m_cfg[i+1][7] && m_cfg[i+1][4:3] == 2'd1) return 1'b1;
    return 1'b0;
  endfunction

  // Issue one CSR op and advance the model to the cycle its response is visible.
  task automatic op(input bit we, input bit [1:0] opc, input bit [11:0] a,
                    input bit [31:0] wd, input bit [1:0] p);
    bit [31:0] old, nv;
    bit [7:0]  b;
    bit [7:0]  p_cfg[4];
    bit [31:0] p_addr[4];
    bit        legal, changed;
    csr_req = 1'b1; csr_we = we; csr_op = opc; csr_addr = a; csr_wdata = wd; csr_priv = p;
    old = m_read(a);
    legal = m_legal(a, p);
    p_cfg = m_cfg;
    p_addr = m_addr;
    changed = 1'b0;
    case (opc)
      OpRw: nv = wd;
      OpRs: nv = old | wd;
      OpRc: nv = old & ~wd;
      default: nv = old;
    endcase
    if (legal && we && opc != OpRd) begin
      if (a == 12'h3A0) begin
        for (int i = 0; i < 4; i++) begin
          if (!m_cfg[i][7]) begin
            b = (nv >> (8 * i)) & 32'h9F;
            if ((b & 8'h03) == 8'h02) b = b & 8'hFD;
            p_cfg[i] = b;
            if (b != m_cfg[i]) changed = 1'b1;
          end
        end
      end else if (a >= 12'h3B0 && a <= 12'h3B3 && !m_addr_locked(a - 12'h3B0)) begin
        p_addr[a - 12'h3B0] = nv;
        if (nv != m_addr[a - 12'h3B0]) changed = 1'b1;
      end
    end
    @(posedge clk); #1;
    m_cfg = p_cfg;
    m_addr = p_addr;
    exp_rvalid = 1'b1;
    exp_rdata = legal ? old : 32'd0;
    exp_illegal = !legal;
    exp_update = changed;
    csr_req = 1'b0; csr_we = 1'b0;
  endtask

  task automatic idle();
    csr_req = 1'b0; csr_we = 1'b0;
    @(posedge clk); #1;
    exp_rvalid = 1'b0; exp_rdata = '0; exp_illegal = 1'b0; exp_update = 1'b0;
  endtask

  task automatic zero_model();
    for (int i = 0; i < 4; i++) begin
      m_cfg[i] = '0;
      m_addr[i] = '0;
    end
    exp_rvalid = 1'b0; exp_rdata = '0; exp_illegal = 1'b0; exp_update = 1'b0;
  endtask

  task automatic do_reset();
    zero_model();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Per-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    chk("rvalid",  {31'd0, csr_rvalid},  {31'd0, exp_rvalid});
    chk("rdata",   csr_rdata,            exp_rdata);
    chk("illegal", {31'd0, csr_illegal}, {31'd0, exp_illegal});
    chk("update",  {31'd0, pmp_update},  {31'd0, exp_update});
    chk("pmpcfg0", pmpcfg0,  {m_cfg[3], m_cfg[2], m_cfg[1], m_cfg[0]});
    chk("pmpcfg1", pmpcfg1,  32'd0);
    chk("pmpaddr0", pmpaddr0, m_addr[0]);
    chk("pmpaddr1", pmpaddr1, m_addr[1]);
    chk("pmpaddr2", pmpaddr2, m_addr[2]);
    chk("pmpaddr3", pmpaddr3, m_addr[3]);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    zero_model();
    @(posedge clk); #1;
    rst = 1'b0;
    idle();

    // Reset asserted while a write of pmpaddr0 is pending.
    csr_req = 1'b1; csr_we = 1'b1; csr_op = OpRw; csr_addr = 12'h3B0;
    csr_wdata = 32'h1234; csr_priv = PrivM;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    csr_req = 1'b0; csr_we = 1'b0;
    rst = 1'b0;
    idle();
    chk("rst_addr0", pmpaddr0, 32'h0);
    chk("rst_cfg0", pmpcfg0, 32'h0);
    chk("rst_rvalid", {31'd0, csr_rvalid}, 32'h0);

    // WARL legalisation of pmpcfg0.
    op(1, OpRw, 12'h3A0, 32'h0000_0F1A, PrivM);
    chk("warl_cfg", pmpcfg0, 32'h0000_0F18);
    chk("warl_upd", {31'd0, pmp_update}, 32'h1);
    op(0, OpRd, 12'h3A0, 32'h0, PrivM);
    chk("warl_rd", csr_rdata, 32'h0000_0F18);
    chk("warl_upd2", {31'd0, pmp_update}, 32'h0);
    // Same legalised value again: no pulse.
    op(1, OpRw, 12'h3A0, 32'h0000_0F7A, PrivM);
    chk("warl_same", {31'd0, pmp_update}, 32'h0);
    idle();

    // Lock all entries.
    do_reset();
    op(1, OpRw, 12'h3A0, 32'hFFFF_FFFF, PrivM);
    chk("lock_cfg", pmpcfg0, 32'h9F9F_9F9F);
    op(1, OpRw, 12'h3A0, 32'h0, PrivM);
    chk("lock_rd", csr_rdata, 32'h9F9F_9F9F);
    chk("lock_keep", pmpcfg0, 32'h9F9F_9F9F);
    chk("lock_noupd", {31'd0, pmp_update}, 32'h0);
    op(1, OpRw, 12'h3B3, 32'hABCD, PrivM);
    chk("lock_addr3", pmpaddr3, 32'h0);
    idle();

    // TOR lock on entry 1, ops back to back.
    do_reset();
    op(1, OpRw, 12'h3A0, 32'h0000_8800, PrivM);
    op(1, OpRw, 12'h3B0, 32'h1234, PrivM);
    op(1, OpRw, 12'h3B1, 32'h5678, PrivM);
    op(1, OpRw, 12'h3B2, 32'h9, PrivM);
    idle();
    chk("tor_addr0", pmpaddr0, 32'h0);
    chk("tor_addr1", pmpaddr1, 32'h0);
    chk("tor_addr2", pmpaddr2, 32'h9);

    // Set / clear on pmpaddr2.
    op(1, OpRw, 12'h3B2, 32'hF0, PrivM);
    op(1, OpRs, 12'h3B2, 32'h0F, PrivM);
    chk("rs_rd", csr_rdata, 32'hF0);
    chk("rs_new", pmpaddr2, 32'hFF);
    op(1, OpRc, 12'h3B2, 32'hF0, PrivM);
    chk("rc_rd", csr_rdata, 32'hFF);
    chk("rc_new", pmpaddr2, 32'h0F);
    op(0, OpRs, 12'h3B2, 32'hF0, PrivM);
    chk("rs_nowe", pmpaddr2, 32'h0F);
    idle();

    // Illegal accesses and unimplemented CSRs.
    op(1, OpRw, 12'h3A0, 32'h1F, PrivS);
    chk("ill_priv", {31'd0, csr_illegal}, 32'h1);
    chk("ill_rdata", csr_rdata, 32'h0);
    chk("ill_cfg", pmpcfg0, 32'h0000_8800);
    op(1, OpRw, 12'h3B3, 32'h77, PrivU);
    op(1, OpRw, 12'h3C0, 32'h1, PrivM);
    chk("ill_addr", {31'd0, csr_illegal}, 32'h1);
    op(0, OpRd, 12'h3B7, 32'h0, PrivM);
    chk("unimp_rd", csr_rdata, 32'h0);
    chk("unimp_ill", {31'd0, csr_illegal}, 32'h0);
    op(1, OpRw, 12'h3B7, 32'hFFFF, PrivM);
    op(1, OpRw, 12'h3A1, 32'hFFFF, PrivM);
    chk("unimp_upd", {31'd0, pmp_update}, 32'h0);
    op(1, OpRw, 12'h3B3, 32'hDEAD_BEEF, PrivM);
    op(0, OpRd, 12'h3B3, 32'h0, PrivM);
    chk("addr3_rd", csr_rdata, 32'hDEAD_BEEF);
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
